// File: rtl/noc_pkg.sv
// Shared NoC definitions for the corner router.
// Holds the flit type codes, port indices and small port helpers.
package noc_pkg;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [1:0] P_L = 2'd0;
  localparam logic [1:0] P_N = 2'd1;
  localparam logic [1:0] P_W = 2'd2;

  // DATASIZE field offsets: the type field is bits [1:0]
  localparam int FT_LSB = 0;
  localparam int FT_W   = 2;

  typedef enum logic {
    S_OPEN,
    S_LOCK
  } lock_st_t;

  function automatic logic [1:0] next_port(
    input logic [1:0] p
  );
    logic [1:0] n;
    unique case (p)
      P_L:     n = P_N;
      P_N:     n = P_W;
      default: n = P_L;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] onehot3(
    input logic [1:0] p
  );
    logic [2:0] o;
    unique case (p)
      P_N:     o = 3'b010;
      P_W:     o = 3'b100;
      default: o = 3'b001;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way rotating-priority picker.
// Searches req from ptr in the order L->N->W->L.
module rr_pick3
  import noc_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    unique case (ptr)
      P_N: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      P_W: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/out_port_sched3.sv
// Output-port scheduler: round-robin arbitration,
// wormhole lock per packet and downstream credit gating.
module out_port_sched3
  import noc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [5:0]       ftype,
  input  logic             credit_ret,
  output logic [2:0]       grant,
  output logic             locked,
  output logic [WIDTH:0]   credit_cnt,
  output logic             err
);

  localparam logic [WIDTH:0] CNT_MAX = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0] CNT_ONE = (WIDTH+1)'(1);

  lock_st_t       st_q, st_d;
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     rr_q, rr_d;
  logic [WIDTH:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [2:0]     pick_gnt;
  logic           fire;
  logic [1:0]     gidx;
  logic [1:0]     ft;

  rr_pick3 u_pick (
    .req (req),
    .ptr (rr_q),
    .gnt (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_OPEN;
      owner_q <= P_L;
      rr_q    <= P_L;
      cnt_q   <= CNT_MAX;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Grant is gated by reset and by an empty credit pool
  always_comb begin
    grant = 3'b000;
    if (rst_n && cnt_q != '0) begin
      if (st_q == S_LOCK)
        grant = req[owner_q] ? onehot3(owner_q) : 3'b000;
      else
        grant = pick_gnt;
    end
  end

  assign fire       = |grant;
  assign locked     = (st_q == S_LOCK);
  assign credit_cnt = cnt_q;
  assign err        = err_q;

  always_comb begin
    gidx = P_L;
    unique case (1'b1)
      grant[1]: gidx = P_N;
      grant[2]: gidx = P_W;
      default:  gidx = P_L;
    endcase
  end

  assign ft = ftype[FT_W*int'(gidx) + FT_LSB +: FT_W];

  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q;
    if (fire) begin
      unique case (st_q)
        S_OPEN: begin
          if (ft == FT_HEAD) begin
            st_d    = S_LOCK;
            owner_d = gidx;
          end else begin
            rr_d = next_port(gidx);
            // stray BODY/TAIL is forwarded as a single flit
            if (ft != FT_SINGLE) err_d = 1'b1;
          end
        end
        default: begin
          if (ft == FT_TAIL) begin
            st_d = S_OPEN;
            rr_d = next_port(owner_q);
          end else if (ft != FT_BODY) begin
            err_d = 1'b1;
          end
        end
      endcase
    end
    cnt_d = cnt_q;
    unique case ({fire, credit_ret})
      2'b10: cnt_d = cnt_q - CNT_ONE;
      2'b01: begin
        if (cnt_q == CNT_MAX) err_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_ONE;
      end
      default: cnt_d = cnt_q;
    endcase
  end

endmodule
